// File: rtl/tx_ser_pkg.sv
// Shared types and CRC-16 constants for the transmit bit-source serializer.
// The CRC step function is reused by any serial CRC-16 (poly 0x1021) user.
package tx_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CRC,
    ST_DONE
  } state_e;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

  // One MSB-first CRC-16 step, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tx_bitsrc_serializer_if.sv
// Word-parallel source bus: N_SRC packed words with per-source valid/ready.
// The data sources use the master modport, the serializer the slave modport.
interface tx_bitsrc_serializer_if #(
  parameter int N_SRC  = 4,
  parameter int WORD_W = 16
);

  logic [N_SRC*WORD_W-1:0] src_data;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;

  modport master (output src_data, output src_valid, input  src_ready);
  modport slave  (input  src_data, input  src_valid, output src_ready);

endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 register (poly 0x1021, preset 0xFFFF, MSB-first).
// init has priority over en so a new frame can start on any cycle.
module crc16_serial
  import tx_ser_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      crc_out <= CRC16_PRESET;
    end else if (en) begin
      crc_out <= crc16_step(crc_out, bit_in);
    end
  end

endmodule

// File: rtl/tx_bitsrc_serializer.sv
// Selects one of N_SRC word sources, fetches words via valid/ready and
// serialises them MSB-first to the sequencer, optionally followed by CRC-16.
module tx_bitsrc_serializer
  import tx_ser_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [CNT_W-1:0]         word_count,
  input  logic                     append_crc,
  tx_bitsrc_serializer_if.slave    src,
  input  logic                     bit_req,
  output logic                     bitsrc,
  output logic                     datadone,
  output logic                     busy,
  output logic                     underrun
);

  localparam int BCNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

  state_e              state;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    words_left;
  logic                crc_q;
  logic [WORD_W-1:0]   shreg;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [3:0]          crc_cnt;
  logic                underrun_q;

  logic                start_ok;
  logic                sel_ok;
  logic [WORD_W-1:0]   sel_word;
  logic                sel_valid;
  logic [N_SRC-1:0]    ready_vec;
  logic [15:0]         crc_val;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  assign sel_ok   = int'(src_sel) < N_SRC;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_word  = '0;
    sel_valid = 1'b0;
    ready_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_word     = src.src_data[i*WORD_W +: WORD_W];
        sel_valid    = src.src_valid[i];
        ready_vec[i] = (state == ST_LOAD);
      end
    end
  end

  assign src.src_ready = ready_vec;

  crc16_serial u_crc (
    .clk     (clk),
    .reset   (reset),
    .init    (start_ok),
    .en      (state == ST_SHIFT && bit_req),
    .bit_in  (shreg[WORD_W-1]),
    .crc_out (crc_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      words_left <= '0;
      crc_q      <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      crc_cnt    <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sel_q      <= src_sel;
            words_left <= word_count;
            crc_q      <= append_crc;
            bit_cnt    <= '0;
            crc_cnt    <= '0;
            underrun_q <= 1'b0;
            if (!sel_ok) begin
              state      <= ST_DONE;
              underrun_q <= 1'b1;
            end else if (word_count != '0) begin
              state <= ST_LOAD;
            end else if (append_crc) begin
              state <= ST_CRC;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          // A request with nothing loaded loses that bit for good.
          if (bit_req) underrun_q <= 1'b1;
          if (sel_valid) begin
            shreg   <= sel_word;
            bit_cnt <= '0;
            if (words_left != '0) words_left <= words_left - 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_req) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              if (words_left != '0) begin
                state <= ST_LOAD;
              end else if (crc_q) begin
                state   <= ST_CRC;
                crc_cnt <= '0;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_CRC: begin
          if (bit_req) begin
            crc_cnt <= crc_cnt + 1'b1;
            if (crc_cnt == 4'd15) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The CRC is frozen during transmission; indexing it replaces a zero-fill shift.
  always_comb begin
    case (state)
      ST_SHIFT: bitsrc = shreg[WORD_W-1];
      ST_CRC:   bitsrc = ~crc_val[4'd15 - crc_cnt];
      default:  bitsrc = 1'b0;
    endcase
  end

  assign datadone = (state == ST_DONE);
  assign busy     = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_CRC);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_tx_bitsrc_serializer.sv
// Bench for tx_bitsrc_serializer: an 8-bit/4-source and a 16-bit/3-source
// instance share control inputs; each test observes one of them.
module tb_tx_bitsrc_serializer;

  logic       clk = 1'b0;
  logic       reset, start, append_crc, bit_req;
  logic [1:0] src_sel;
  logic [7:0] word_count;

  always #5 clk = ~clk;

  tx_bitsrc_serializer_if #(.N_SRC(4), .WORD_W(8))  s8  ();
  tx_bitsrc_serializer_if #(.N_SRC(3), .WORD_W(16)) s16 ();

  logic bitsrc8, datadone8, busy8, underrun8;
  logic bitsrc16, datadone16, busy16, underrun16;

  tx_bitsrc_serializer #(.N_SRC(4), .WORD_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
    .word_count(word_count), .append_crc(append_crc), .src(s8),
    .bit_req(bit_req), .bitsrc(bitsrc8), .datadone(datadone8),
    .busy(busy8), .underrun(underrun8)
  );

  tx_bitsrc_serializer #(.N_SRC(3), .WORD_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
    .word_count(word_count), .append_crc(append_crc), .src(s16),
    .bit_req(bit_req), .bitsrc(bitsrc16), .datadone(datadone16),
    .busy(busy16), .underrun(underrun16)
  );

  // Observed instance.
  logic       use16;
  logic       cur_bitsrc, cur_done, cur_busy, cur_under;
  logic [3:0] cur_ready;
  assign cur_bitsrc = use16 ? bitsrc16   : bitsrc8;
  assign cur_done   = use16 ? datadone16 : datadone8;
  assign cur_busy   = use16 ? busy16     : busy8;
  assign cur_under  = use16 ? underrun16 : underrun8;
  assign cur_ready  = use16 ? {1'b0, s16.src_ready} : s8.src_ready;

  // Source models and scoreboard.
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic        exp_q[$];
  int          src8_idx, src16_idx;
  logic        en8, en16;
  logic [3:0]  noise8;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    logic pend8, pend16;
    pend8 = 1'b0;
    pend16 = 1'b0;
    s8.src_data = '0;  s8.src_valid = '0;
    s16.src_data = '0; s16.src_valid = '0;
    forever begin
      @(negedge clk);
      if (pend8 && q8.size() > 0) void'(q8.pop_front());
      if (pend16 && q16.size() > 0) void'(q16.pop_front());
      s8.src_data  = {4{8'hEE}};
      s8.src_valid = noise8;
      if (en8 && q8.size() > 0) begin
        s8.src_data[src8_idx*8 +: 8] = q8[0];
        s8.src_valid[src8_idx] = 1'b1;
      end
      s16.src_data  = {3{16'hEEEE}};
      s16.src_valid = '0;
      if (en16 && q16.size() > 0) begin
        s16.src_data[src16_idx*16 +: 16] = q16[0];
        s16.src_valid[src16_idx] = 1'b1;
      end
      pend8  = en8 && q8.size() > 0 && s8.src_ready[src8_idx];
      pend16 = en16 && q16.size() > 0 && s16.src_ready[src16_idx];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word8(input logic [7:0] w);
    q8.push_back(w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic push_word16(input logic [15:0] w);
    q16.push_back(w);
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic push_crc(input logic [15:0] c);
    for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bit_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    q8.delete(); q16.delete(); exp_q.delete();
    tick();
  endtask

  task automatic start_xfer(input logic [1:0] sel, input logic [7:0] cnt, input logic crc);
    src_sel = sel; word_count = cnt; append_crc = crc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pull n bits from the observed DUT, one bit_req every gap cycles.
  task automatic consume(input int n, input int gap, input string tag);
    logic b;
    for (int k = 0; k < n; k++) begin
      repeat (gap - 1) tick();
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s bit%0d: scoreboard empty", tag, k);
      end else begin
        b = exp_q.pop_front();
        check($sformatf("%s bit%0d", tag, k), {31'd0, cur_bitsrc}, {31'd0, b});
      end
      check($sformatf("%s ready%0d", tag, k), {28'd0, cur_ready}, 32'd0);
      bit_req = 1'b1;
      tick();
      bit_req = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] cnt;
    logic       crc;
    logic       e_busy;
    logic       e_done;
    logic       e_under;
    logic [2:0] e_ready;
  } vec_t;

  vec_t vt[5];
  logic [7:0] msg[9];

  initial begin
    reset = 1'b1; start = 1'b0; bit_req = 1'b0; append_crc = 1'b0;
    src_sel = '0; word_count = '0; use16 = 1'b0;
    src8_idx = 0; src16_idx = 0; en8 = 1'b1; en16 = 1'b1; noise8 = '0;

    vt[0] = '{2'd1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
    vt[1] = '{2'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
    vt[2] = '{2'd2, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
    vt[3] = '{2'd3, 8'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000};
    vt[4] = '{2'd2, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100};
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state of both instances.
    do_reset();
    check("rst8 outs",  {27'd0, s8.src_ready, bitsrc8, datadone8, busy8, underrun8}, 32'd0);
    check("rst16 outs", {28'd0, s16.src_ready, bitsrc16, datadone16, busy16, underrun16}, 32'd0);

    // Start decisions on the 3-source instance (sel=3 is out of range).
    use16 = 1'b1;
    for (int v = 0; v < 5; v++) begin
      do_reset();
      start_xfer(vt[v].sel, vt[v].cnt, vt[v].crc);
      check($sformatf("vec%0d busy", v),  {31'd0, busy16},     {31'd0, vt[v].e_busy});
      check($sformatf("vec%0d done", v),  {31'd0, datadone16}, {31'd0, vt[v].e_done});
      check($sformatf("vec%0d under", v), {31'd0, underrun16}, {31'd0, vt[v].e_under});
      check($sformatf("vec%0d ready", v), {29'd0, s16.src_ready}, {29'd0, vt[v].e_ready});
      check($sformatf("vec%0d bitsrc", v), {31'd0, bitsrc16}, 32'd0);
    end

    // Single 16-bit word A5C3 from source 1, no CRC.
    do_reset();
    src16_idx = 1;
    push_word16(16'hA5C3);
    tick();
    start_xfer(2'd1, 8'd1, 1'b0);
    check("a5c3 load ready", {28'd0, cur_ready}, 32'h2);
    consume(16, 2, "a5c3");
    check("a5c3 done",  {31'd0, cur_done}, 32'd1);
    check("a5c3 busy",  {31'd0, cur_busy}, 32'd0);
    check("a5c3 ready", {28'd0, cur_ready}, 32'd0);

    // "123456789" + CRC-16/GENIBUS on the 8-bit instance.
    use16 = 1'b0;
    do_reset();
    src8_idx = 2;
    for (int i = 0; i < 9; i++) push_word8(msg[i]);
    push_crc(16'hD64E);
    tick();
    start_xfer(2'd2, 8'd9, 1'b1);
    consume(87, 4, "crc9");
    check("crc9 done early", {31'd0, cur_done}, 32'd0);
    consume(1, 4, "crc9 last");
    check("crc9 done", {31'd0, cur_done}, 32'd1);
    check("crc9 busy", {31'd0, cur_busy}, 32'd0);

    // Underrun: source withholds valid while two bit requests arrive.
    do_reset();
    src8_idx = 0; en8 = 1'b0;
    push_word8(8'h96);
    tick();
    start_xfer(2'd0, 8'd1, 1'b0);
    check("ur initial", {31'd0, cur_under}, 32'd0);
    tick();
    bit_req = 1'b1; tick(); bit_req = 1'b0;
    tick();
    bit_req = 1'b1; tick(); bit_req = 1'b0;
    check("ur set",    {31'd0, cur_under}, 32'd1);
    check("ur bitsrc", {31'd0, cur_bitsrc}, 32'd0);
    check("ur ready",  {28'd0, cur_ready}, 32'h1);
    en8 = 1'b1;
    tick();
    consume(8, 4, "ur word");
    check("ur done",   {31'd0, cur_done}, 32'd1);
    check("ur sticky", {31'd0, cur_under}, 32'd1);
    start_xfer(2'd0, 8'd0, 1'b0);
    check("ur cleared", {31'd0, cur_under}, 32'd0);

    // Zero words with CRC: complement of the preset is all zeros.
    do_reset();
    push_crc(16'h0000);
    start_xfer(2'd2, 8'd0, 1'b1);
    check("crc0 busy", {31'd0, cur_busy}, 32'd1);
    consume(16, 2, "crc0");
    check("crc0 done", {31'd0, cur_done}, 32'd1);

    // Reset during word 2 of 3, then a clean transfer.
    do_reset();
    src8_idx = 3;
    push_word8(8'h11); push_word8(8'h22); push_word8(8'h33);
    tick();
    start_xfer(2'd3, 8'd3, 1'b1);
    consume(11, 4, "mid");
    reset = 1'b1;
    tick();
    check("mid rst outs", {27'd0, s8.src_ready, bitsrc8, datadone8, busy8, underrun8}, 32'd0);
    reset = 1'b0;
    q8.delete(); exp_q.delete();
    tick(); tick();
    for (int i = 0; i < 9; i++) push_word8(msg[i]);
    push_crc(16'hD64E);
    tick();
    start_xfer(2'd3, 8'd9, 1'b1);
    consume(88, 4, "post");
    check("post done", {31'd0, cur_done}, 32'd1);

    // Start during SHIFT with another selection is ignored; source 0 is noisy.
    do_reset();
    src8_idx = 1; noise8 = 4'b0001;
    push_word8(8'h5A); push_word8(8'hF0);
    tick();
    start_xfer(2'd1, 8'd2, 1'b0);
    consume(3, 4, "ign a");
    start_xfer(2'd0, 8'd5, 1'b1);
    consume(12, 4, "ign b");
    check("ign done early", {31'd0, cur_done}, 32'd0);
    consume(1, 4, "ign last");
    check("ign done",  {31'd0, cur_done}, 32'd1);
    check("ign under", {31'd0, cur_under}, 32'd0);
    check("ign ready", {28'd0, cur_ready}, 32'd0);
    check("ign sb",    exp_q.size(), 32'd0);
    noise8 = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
